// File: rtl/mips_mc_ctrl_if.sv
// Memory handshake bundle between the multi-cycle control unit and memory.
//   mem_req   : controller requests a memory access this cycle
//   iord      : address select, 0 = PC, 1 = ALUOut
//   memwrite  : write strobe, meaningful only while mem_req is high
//   mem_ready : memory completes the current access this cycle
// master = controller side, slave = memory side.
interface mips_mc_ctrl_if;
  logic mem_req;
  logic iord;
  logic memwrite;
  logic mem_ready;

  modport master (output mem_req, output iord, output memwrite, input mem_ready);
  modport slave  (input mem_req, input iord, input memwrite, output mem_ready);
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit. Sequences lw/sw/R-type/beq/addi/j through
// FETCH, DECODE, execute, memory and write-back states, with a mem_ready
// handshake for wait-state memories and a retired-instruction counter.
// Ports:
//   clk, reset (async active-low)  : clock and reset
//   mem (master modport)           : mem_req/iord/memwrite out, mem_ready in
//   opcode, zero                   : instruction opcode and ALU zero flag
//   irwrite, pc_en, pcsrc, regdst, memtoreg, regwrite,
//   alusrca, alusrcb, aluop        : datapath controls
//   state, illegal, retired        : debug state, bad-opcode pulse, counter
module mips_mc_ctrl #(
  parameter int OP_W        = 6,
  parameter int CNT_W       = 16,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  mips_mc_ctrl_if.master    mem,
  input  logic [OP_W-1:0]   opcode,
  input  logic              zero,
  output logic              irwrite,
  output logic              pc_en,
  output logic [1:0]        pcsrc,
  output logic              regdst,
  output logic              memtoreg,
  output logic              regwrite,
  output logic              alusrca,
  output logic [1:0]        alusrcb,
  output logic [1:0]        aluop,
  output logic [3:0]        state,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_e;

  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_RTYP = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

  state_e            state_q, state_d;
  logic              is_sw_q, is_sw_d;   // lw/sw decided in DECODE; opcode is not looked at later
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              ready;
  logic              retire;

  assign ready = (MEM_WAIT_EN != 0) ? mem.mem_ready : 1'b1;

  always_comb begin
    state_d      = state_q;
    is_sw_d      = is_sw_q;
    retire       = 1'b0;
    mem.mem_req  = 1'b0;
    mem.iord     = 1'b0;
    mem.memwrite = 1'b0;
    irwrite      = 1'b0;
    pc_en        = 1'b0;
    pcsrc        = 2'b00;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    aluop        = 2'b00;
    illegal      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        alusrcb     = 2'b01;
        irwrite     = ready;
        pc_en       = ready;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = S_MEMADR;
          is_sw_d = (opcode == OP_SW);
        end else if (opcode == OP_RTYP) state_d = S_EXEC;
        else if (opcode == OP_BEQ)      state_d = S_BRANCH;
        else if (opcode == OP_ADDI)     state_d = S_ADDIEX;
        else if (opcode == OP_J)        state_d = S_JUMP;
        else begin
          state_d = S_FETCH;
          illegal = 1'b1;
        end
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem.mem_req  = 1'b1;
        mem.iord     = 1'b1;
        mem.memwrite = 1'b1;
        if (ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        pc_en   = zero;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset blanks every control combinationally so an in-flight access is
    // dropped at once, not at the next edge.
    if (!reset) begin
      mem.mem_req  = 1'b0;
      mem.iord     = 1'b0;
      mem.memwrite = 1'b0;
      irwrite      = 1'b0;
      pc_en        = 1'b0;
      pcsrc        = 2'b00;
      regdst       = 1'b0;
      memtoreg     = 1'b0;
      regwrite     = 1'b0;
      alusrca      = 1'b0;
      alusrcb      = 2'b00;
      aluop        = 2'b00;
      illegal      = 1'b0;
    end
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      is_sw_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      is_sw_q   <= is_sw_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule
